// File: rtl/uart_pkg.sv
// Shared UART constants: TX state encodings, parity type and stop-bit selectors.
// Used by the TX block and shared with the RX block.
package uart_pkg;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP1  = 3'd4;
    localparam logic [2:0] TX_STOP2  = 3'd5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter; load takes effect on the next edge, LSB presented first.
// No backpressure: shifts every cycle i_shift is high, o_done flags the last data bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic                  o_bit,
    output logic                  o_done
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_cnt   <= o_done ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_bit  = r_shift[0];
    assign o_done = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, 1 or 2 stops.
// Frame starts the cycle after DATA_VALID is taken; requests outside IDLE/final stop are dropped.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_done
);

    logic [2:0] r_state;
    logic       r_par_en;
    logic       r_par_bit;
    logic       r_stop2;

    logic [2:0] w_next;
    logic       w_final;
    logic       w_accept;
    logic       w_ser_bit;
    logic       w_ser_done;

    assign w_final  = ((r_state == TX_STOP1) && (r_stop2 != STOP_2)) || (r_state == TX_STOP2);
    assign w_accept = DATA_VALID && ((r_state == TX_IDLE) || w_final);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_ser (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_load  (w_accept),
        .i_data  (P_DATA),
        .i_shift (r_state == TX_DATA),
        .o_bit   (w_ser_bit),
        .o_done  (w_ser_done)
    );

    always_comb begin
        w_next = TX_IDLE;
        case (r_state)
            TX_IDLE:   w_next = DATA_VALID ? TX_START : TX_IDLE;
            TX_START:  w_next = TX_DATA;
            TX_DATA:   w_next = !w_ser_done ? TX_DATA : (r_par_en ? TX_PARITY : TX_STOP1);
            TX_PARITY: w_next = TX_STOP1;
            TX_STOP1:  w_next = (r_stop2 == STOP_2) ? TX_STOP2 : (DATA_VALID ? TX_START : TX_IDLE);
            TX_STOP2:  w_next = DATA_VALID ? TX_START : TX_IDLE;
            default:   w_next = TX_IDLE;
        endcase
    end

    // Config is latched with the word so mid-frame input changes cannot disturb the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= TX_IDLE;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_par_en  <= PAR_EN;
                r_par_bit <= (^P_DATA) ^ PAR_TYP;
                r_stop2   <= STOP2;
            end
        end
    end

    always_comb begin
        TX_OUT = 1'b1;
        busy   = 1'b1;
        case (r_state)
            TX_START:  TX_OUT = 1'b0;
            TX_DATA:   TX_OUT = w_ser_bit;
            TX_PARITY: TX_OUT = r_par_bit;
            TX_STOP1:  TX_OUT = 1'b1;
            TX_STOP2:  TX_OUT = 1'b1;
            default:   busy   = 1'b0;
        endcase
    end

    assign tx_done = w_final;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frames plus random traffic against a queue-based line model.
module tb_uart_tx_cfg;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic       TX_OUT;
    logic       busy;
    logic       tx_done;

    int n_chk = 0;
    int n_bad = 0;

    // Expected per-cycle line state {tx, busy, done}; empty queue means idle.
    logic [2:0]  exp_q[$];
    logic [63:0] trace;
    int          ntrace;

    uart_tx_cfg #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // A frame as the receiver would see it on the wire.
    function automatic void push_frame(input logic [7:0] d, input bit pe, input bit pt, input bit s2);
        int  ones;
        bit  par;
        ones = $countones(d);
        par  = pt ? (ones % 2 == 0) : (ones % 2 == 1);
        exp_q.push_back(3'b010);
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 2'b10});
        if (pe) exp_q.push_back({par, 2'b10});
        if (s2) exp_q.push_back(3'b110);
        exp_q.push_back(3'b111);
    endfunction

    task automatic step(input bit dv, input logic [7:0] d, input bit pe, input bit pt, input bit s2);
        logic [2:0] cur;
        @(negedge CLK);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else cur = 3'b100;
        chk("tx_out", TX_OUT, cur[2]);
        chk("busy", busy, cur[1]);
        chk("tx_done", tx_done, cur[0]);
        if (busy) begin
            trace = {trace[62:0], TX_OUT};
            ntrace++;
        end
        DATA_VALID = dv;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2      = s2;
        if (dv && (!cur[1] || cur[0])) push_frame(d, pe, pt, s2);
    endtask

    task automatic idle_step();
        step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) idle_step();
    endtask

    task automatic clr_trace();
        trace  = '0;
        ntrace = 0;
    endtask

    initial begin
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        clr_trace();
        #3;
        chk("rst_tx_out", TX_OUT, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        idle_steps(20);

        // 0xA5, even parity, one stop
        clr_trace();
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle_steps(13);
        chk("a5_even_bits", trace[10:0], 11'b01010010101);
        chk("a5_even_len", ntrace, 11);

        // 0xA5, odd parity, two stops
        clr_trace();
        step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        idle_steps(14);
        chk("a5_odd_bits", trace[11:0], 12'b010100101111);
        chk("a5_odd_len", ntrace, 12);

        // 0x3C then 0xFF back-to-back, requested in the final stop cycle
        clr_trace();
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle_steps(9);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle_steps(12);
        chk("b2b_bits", trace[19:0], 20'b00011110010111111111);
        chk("b2b_len", ntrace, 20);

        // 0x55 requested mid-DATA of 0x0F is dropped
        clr_trace();
        step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
        idle_steps(3);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
        idle_steps(12);
        chk("drop_bits", trace[9:0], 10'b0111100001);
        chk("drop_len", ntrace, 10);

        // Reset during data bit 4
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        idle_steps(6);
        #2 RST = 1'b0;
        #1;
        chk("arst_tx_out", TX_OUT, 1'b1);
        chk("arst_busy", busy, 1'b0);
        chk("arst_tx_done", tx_done, 1'b0);
        exp_q.delete();
        DATA_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        idle_steps(3);
        clr_trace();
        step(1'b1, 8'h81, 1'b1, 1'b0, 1'b1);
        idle_steps(14);
        chk("post_rst_bits", trace[11:0], 12'b010000001011);
        chk("post_rst_len", ntrace, 12);

        // Random traffic, including requests landing mid-frame and in final stop cycles
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else
                idle_step();
        end
        idle_steps(16);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter for the UART system's TX path. It combines frame sequencing, serialisation and parity generation in one block.
Generalised beyond the fixed 8-bit/even-only TX control: configurable data width, selectable even/odd parity, one or two stop bits, and back-to-back frames with no idle gap.
Runs on the TX (baud-rate) clock; one frame bit per CLK cycle.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..16).
CNT_W, $clog2(DATA_WIDTH), width of the data-bit counter (derived; not overridden).

Ports:
CLK  input  1  TX clock, one bit period per cycle.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  parallel data word to send.
DATA_VALID  input  1  request to send P_DATA; sampled on rising CLK.
PAR_EN  input  1  1 = parity bit inserted.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  1 = two stop bits, 0 = one stop bit.
TX_OUT  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress.
tx_done  output  1  one-cycle pulse in the final stop-bit cycle.

Behaviour:
- Clock and reset: one clock (CLK). Reset RST is asynchronous and active-low.
- Reset values: state=IDLE, TX_OUT=1, busy=0, tx_done=0, bit counter=0, holding registers=0.
- Reset mid-frame: the frame aborts immediately and TX_OUT returns to 1 asynchronously; there is no partial-frame completion.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. Outputs are Moore-decoded from registered state/counter/shift data.
- IDLE: TX_OUT=1, busy=0. On DATA_VALID=1 at edge k:
  - latch P_DATA, PAR_EN, PAR_TYP and STOP2 into holding registers;
  - compute parity = ^P_DATA ^ PAR_TYP and latch it;
  - enter START at edge k.
- Config inputs are ignored after capture; changing them mid-frame has no effect on the current frame.
- START: TX_OUT=0, busy=1, one cycle, then DATA with counter=0.
- DATA: TX_OUT = shift register bit 0 (LSB first). Each cycle the shift register shifts right and the counter increments.
- Leaving DATA: after counter = DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, otherwise STOP1.
- PARITY: TX_OUT = latched parity bit, one cycle, then STOP1.
- STOP1: TX_OUT=1, one cycle. Go to STOP2 if latched STOP2=1; otherwise this is the final stop cycle.
- STOP2: TX_OUT=1, one cycle, final stop cycle.
- Final stop cycle:
  - tx_done=1, busy=1.
  - If DATA_VALID=1 at the end of this cycle: capture a new word/config and go directly to START (busy stays 1, zero idle cycles).
  - Otherwise go to IDLE.
- DATA_VALID in any state other than IDLE or the final stop cycle is ignored; the word is dropped and the source must hold it until busy=0 or tx_done=1.
- Frame length = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 cycles. busy is high for exactly that many cycles per frame.
- Illegal/unused state encodings: behave as IDLE outputs and return to IDLE next cycle.

Decomposition:
- Shared package uart_pkg:
  - TX state encodings (localparams);
  - PAR_EVEN=0 / PAR_ODD=1 constants;
  - STOP_1 / STOP_2 constants (shared with the RX block).
- One natural sub-module, uart_tx_serializer: shift register + bit counter, with load/shift/done signals. The FSM, parity and output mux stay in the top.

Test Plan:
- Reset, then no DATA_VALID for 20 cycles -> TX_OUT=1, busy=0, tx_done=0 throughout.
- DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; busy high for 11 cycles; tx_done in cycle 11 only.
- Same frame with PAR_TYP=1, STOP2=1 -> parity bit = 1, two stop bits, 12-cycle frame.
- PAR_EN=0, P_DATA=0x3C, DATA_VALID re-asserted with 0xFF in the final stop cycle -> frames 0,0,0,1,1,1,1,0,0,1 and 0,1,1,1,1,1,1,1,1,1 back-to-back; busy never drops between them.
- DATA_VALID pulsed with 0x55 mid-DATA while sending 0x0F -> 0x55 never transmitted; 0x0F frame unaltered.
- RST asserted during DATA bit 4 -> TX_OUT=1 and busy=0 immediately. After release, a new 0x81 frame transmits cleanly.
